// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared state encoding and constants for the hazard controller
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        LU_STALL = 2'd2,
        MEM_WAIT = 2'd3
    } state_t;

    localparam logic [4:0] REG_ZERO       = 5'd0;
    localparam int         LU_PENALTY_DEF = 1;

endpackage

// File: rtl/hazard_cmp.sv
// rtl/hazard_cmp.sv - combinational load-use hazard comparator
module hazard_cmp
    import hazard_pkg::*;
(
    input  logic       ID_EX_MemRead_i,
    input  logic [4:0] ID_EX_RT_i,
    input  logic [4:0] IF_ID_RS_i,
    input  logic [4:0] IF_ID_RT_i,
    input  logic       IF_ID_uses_rt_i,
    output logic       lu_haz_o
);

    logic rs_match;
    logic rt_match;

    // A load into $0 never creates a real dependency, so it is filtered out here.
    always_comb begin
        rs_match = (ID_EX_RT_i == IF_ID_RS_i);
        rt_match = IF_ID_uses_rt_i & (ID_EX_RT_i == IF_ID_RT_i);
        lu_haz_o = ID_EX_MemRead_i & (ID_EX_RT_i != REG_ZERO) & (rs_match | rt_match);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush/bubble sequencing with perf counters
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int LU_PENALTY   = LU_PENALTY_DEF,
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             ID_EX_MemRead_i,
    input  logic [4:0]       ID_EX_RT_i,
    input  logic [4:0]       IF_ID_RS_i,
    input  logic [4:0]       IF_ID_RT_i,
    input  logic             IF_ID_uses_rt_i,
    input  logic             branch_taken_i,
    input  logic             dmem_busy_i,
    output logic             PC_write_o,
    output logic             IF_ID_write_o,
    output logic             IF_ID_flush_o,
    output logic             ID_EX_write_o,
    output logic             ID_EX_bubble_o,
    output logic             pipe_hold_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             err_o
);

    localparam int             WW       = $clog2(MEM_WAIT_MAX + 2);
    localparam logic [WW-1:0]  WAIT_MAX = WW'(MEM_WAIT_MAX);
    localparam logic [WW-1:0]  WAIT_SAT = WW'(MEM_WAIT_MAX + 1);
    localparam logic [2:0]     LU_INIT  = 3'(LU_PENALTY - 1);

    state_t             state_q, state_d;
    state_t             ret_q, ret_d;
    state_t             eff_state;
    logic [2:0]         lu_cnt_q, lu_cnt_d;
    logic [WW-1:0]      wait_cnt_q, wait_cnt_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic               lu_haz;

    hazard_cmp u_cmp (
        .ID_EX_MemRead_i (ID_EX_MemRead_i),
        .ID_EX_RT_i      (ID_EX_RT_i),
        .IF_ID_RS_i      (IF_ID_RS_i),
        .IF_ID_RT_i      (IF_ID_RT_i),
        .IF_ID_uses_rt_i (IF_ID_uses_rt_i),
        .lu_haz_o        (lu_haz)
    );

    // The cycle busy drops already behaves as the return state, so no release cycle is lost.
    always_comb begin
        eff_state = state_q;
        if (state_q == MEM_WAIT && !dmem_busy_i) begin
            eff_state = ret_q;
        end
    end

    // State and counter registers; reset forces IDLE even mid-stall.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            ret_q       <= RUN;
            lu_cnt_q    <= 3'd0;
            wait_cnt_q  <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            lu_cnt_q    <= lu_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next-state: busy beats load-use, load-use beats branch; lu_cnt freezes during a wait.
    always_comb begin
        state_d    = eff_state;
        ret_d      = ret_q;
        lu_cnt_d   = lu_cnt_q;
        wait_cnt_d = wait_cnt_q;
        case (eff_state)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (dmem_busy_i) begin
                    state_d    = MEM_WAIT;
                    ret_d      = RUN;
                    wait_cnt_d = WW'(1);
                end else if (lu_haz && LU_PENALTY > 1) begin
                    state_d  = LU_STALL;
                    lu_cnt_d = LU_INIT;
                end
            end
            LU_STALL: begin
                if (dmem_busy_i) begin
                    state_d    = MEM_WAIT;
                    ret_d      = LU_STALL;
                    wait_cnt_d = WW'(1);
                end else if (lu_cnt_q <= 3'd1) begin
                    state_d  = RUN;
                    lu_cnt_d = 3'd0;
                end else begin
                    lu_cnt_d = lu_cnt_q - 3'd1;
                end
            end
            MEM_WAIT: begin
                if (wait_cnt_q < WAIT_SAT) begin
                    wait_cnt_d = wait_cnt_q + WW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        err_d = err_q | (wait_cnt_d > WAIT_MAX);
    end

    // Output decode from the effective state and the current inputs.
    always_comb begin
        PC_write_o     = 1'b0;
        IF_ID_write_o  = 1'b0;
        IF_ID_flush_o  = 1'b0;
        ID_EX_write_o  = 1'b0;
        ID_EX_bubble_o = 1'b0;
        pipe_hold_o    = 1'b0;
        case (eff_state)
            IDLE: begin
                ID_EX_write_o  = 1'b1;
                ID_EX_bubble_o = 1'b1;
            end
            RUN: begin
                if (dmem_busy_i) begin
                    pipe_hold_o = 1'b1;
                end else if (lu_haz) begin
                    ID_EX_write_o  = 1'b1;
                    ID_EX_bubble_o = 1'b1;
                end else begin
                    PC_write_o    = 1'b1;
                    IF_ID_write_o = 1'b1;
                    ID_EX_write_o = 1'b1;
                    IF_ID_flush_o = branch_taken_i;
                end
            end
            LU_STALL: begin
                if (dmem_busy_i) begin
                    pipe_hold_o = 1'b1;
                end else begin
                    ID_EX_write_o  = 1'b1;
                    ID_EX_bubble_o = 1'b1;
                end
            end
            MEM_WAIT: pipe_hold_o = 1'b1;
            default: ;
        endcase
    end

    // Saturating performance counters driven by the decoded outputs.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (state_q != IDLE && !PC_write_o && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (IF_ID_flush_o && flush_cnt_q != '1) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed vector bench for hazard_ctrl
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start, mr, uses_rt, br, busy;
    logic [4:0] ex_rt, rs, rt;

    logic        pc1, ifw1, fl1, idw1, bub1, hold1, err1;
    logic [15:0] scnt1, fcnt1;
    logic        pc3, ifw3, fl3, idw3, bub3, hold3, err3;
    logic [2:0]  scnt3, fcnt3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.LU_PENALTY(1), .MEM_WAIT_MAX(15), .CNT_W(16)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .ID_EX_MemRead_i(mr),
        .ID_EX_RT_i(ex_rt), .IF_ID_RS_i(rs), .IF_ID_RT_i(rt), .IF_ID_uses_rt_i(uses_rt),
        .branch_taken_i(br), .dmem_busy_i(busy), .PC_write_o(pc1), .IF_ID_write_o(ifw1),
        .IF_ID_flush_o(fl1), .ID_EX_write_o(idw1), .ID_EX_bubble_o(bub1), .pipe_hold_o(hold1),
        .stall_cnt_o(scnt1), .flush_cnt_o(fcnt1), .err_o(err1)
    );

    hazard_ctrl #(.LU_PENALTY(3), .MEM_WAIT_MAX(15), .CNT_W(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .ID_EX_MemRead_i(mr),
        .ID_EX_RT_i(ex_rt), .IF_ID_RS_i(rs), .IF_ID_RT_i(rt), .IF_ID_uses_rt_i(uses_rt),
        .branch_taken_i(br), .dmem_busy_i(busy), .PC_write_o(pc3), .IF_ID_write_o(ifw3),
        .IF_ID_flush_o(fl3), .ID_EX_write_o(idw3), .ID_EX_bubble_o(bub3), .pipe_hold_o(hold3),
        .stall_cnt_o(scnt3), .flush_cnt_o(fcnt3), .err_o(err3)
    );

    wire [5:0] o1 = {pc1, ifw1, fl1, idw1, bub1, hold1};
    wire [5:0] o3 = {pc3, ifw3, fl3, idw3, bub3, hold3};

    // exp = {PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble, pipe_hold}
    typedef struct {
        logic       start;
        logic       mr;
        logic [4:0] ex_rt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       br;
        logic       busy;
        logic [5:0] exp;
    } vec_t;

    localparam logic [5:0] O_IDLE  = 6'b000110;
    localparam logic [5:0] O_RUN   = 6'b110100;
    localparam logic [5:0] O_FLUSH = 6'b111100;
    localparam logic [5:0] O_STALL = 6'b000110;
    localparam logic [5:0] O_HOLD  = 6'b000001;

    vec_t vecs [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic m, input logic [4:0] e, input logic [4:0] a,
                         input logic [4:0] b, input logic u, input logic bt, input logic bz);
        start = s; mr = m; ex_rt = e; rs = a; rt = b; uses_rt = u; br = bt; busy = bz;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    task automatic do_start();
        next_cyc();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        //            st mr ex  rs  rt  u  br bz  exp
        vecs[0]  = '{0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_IDLE};
        vecs[1]  = '{1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_IDLE};
        vecs[2]  = '{0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_RUN};
        vecs[3]  = '{0, 1, 5'd2, 5'd2, 5'd4, 1, 0, 0, O_STALL};
        vecs[4]  = '{0, 0, 5'd2, 5'd2, 5'd4, 1, 0, 0, O_RUN};
        vecs[5]  = '{0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0, O_RUN};
        vecs[6]  = '{0, 1, 5'd5, 5'd1, 5'd5, 1, 0, 0, O_STALL};
        vecs[7]  = '{0, 1, 5'd5, 5'd1, 5'd5, 0, 0, 0, O_RUN};
        vecs[8]  = '{0, 0, 5'd0, 5'd1, 5'd2, 0, 1, 0, O_FLUSH};
        vecs[9]  = '{0, 1, 5'd7, 5'd7, 5'd0, 0, 1, 0, O_STALL};
        vecs[10] = '{0, 1, 5'd7, 5'd7, 5'd0, 0, 1, 1, O_HOLD};
        vecs[11] = '{0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, O_HOLD};
        vecs[12] = '{0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, O_FLUSH};
        vecs[13] = '{0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_RUN};

        // reset state
        #3;
        chk("reset_outputs", 32'(o1), 32'(O_IDLE));
        chk("reset_stall_cnt", 32'(scnt1), 32'd0);
        chk("reset_flush_cnt", 32'(fcnt1), 32'd0);
        chk("reset_err", 32'(err1), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;

        // table: LU_PENALTY=1 instance
        for (int i = 0; i < 14; i++) begin
            next_cyc();
            drive(vecs[i].start, vecs[i].mr, vecs[i].ex_rt, vecs[i].rs, vecs[i].rt,
                  vecs[i].uses_rt, vecs[i].br, vecs[i].busy);
            @(negedge clk);
            chk($sformatf("vec%0d_outputs", i), 32'(o1), 32'(vecs[i].exp));
        end
        chk("table_stall_cnt", 32'(scnt1), 32'd5);
        chk("table_flush_cnt", 32'(fcnt1), 32'd2);
        chk("table_err", 32'(err1), 32'd0);

        // LU_PENALTY=3: three bubbles, branch during stall is suppressed
        do_reset();
        do_start();
        next_cyc(); drive(0, 1, 5'd2, 5'd2, 5'd4, 1, 0, 0); @(negedge clk);
        chk("p3_stall1", 32'(o3), 32'(O_STALL));
        next_cyc(); drive(0, 0, 5'd0, 5'd2, 5'd4, 1, 1, 0); @(negedge clk);
        chk("p3_stall2_branch", 32'(o3), 32'(O_STALL));
        next_cyc(); drive(0, 0, 5'd0, 5'd2, 5'd4, 1, 0, 0); @(negedge clk);
        chk("p3_stall3", 32'(o3), 32'(O_STALL));
        next_cyc(); @(negedge clk);
        chk("p3_resume", 32'(o3), 32'(O_RUN));
        chk("p3_stall_cnt", 32'(scnt3), 32'd3);
        chk("p3_flush_cnt", 32'(fcnt3), 32'd0);

        // memory wait in the middle of a load-use stall
        do_reset();
        do_start();
        next_cyc(); drive(0, 1, 5'd2, 5'd2, 5'd4, 1, 0, 0); @(negedge clk);
        chk("mw_c1", 32'(o3), 32'(O_STALL));
        next_cyc(); drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0); @(negedge clk);
        chk("mw_c2", 32'(o3), 32'(O_STALL));
        for (int k = 0; k < 4; k++) begin
            next_cyc(); drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1); @(negedge clk);
            chk($sformatf("mw_hold%0d", k), 32'(o3), 32'(O_HOLD));
        end
        next_cyc(); drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0); @(negedge clk);
        chk("mw_resume_stall", 32'(o3), 32'(O_STALL));
        next_cyc(); @(negedge clk);
        chk("mw_run", 32'(o3), 32'(O_RUN));
        chk("mw_stall_cnt", 32'(scnt3), 32'd7);
        next_cyc(); drive(0, 1, 5'd3, 5'd3, 5'd0, 0, 0, 0); @(negedge clk);
        next_cyc(); drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0); @(negedge clk);
        chk("sat_stall_cnt", 32'(scnt3), 32'd7);
        chk("sat_in_stall", 32'(o3), 32'(O_STALL));
        #1 rst = 1'b0;
        #1;
        chk("midstall_reset_outputs", 32'(o3), 32'(O_IDLE));
        chk("midstall_reset_cnt", 32'(scnt3), 32'd0);
        @(posedge clk);
        #2 rst = 1'b1;

        // timeout: 16 busy cycles on the MEM_WAIT_MAX=15 instance
        do_reset();
        do_start();
        for (int k = 0; k < 16; k++) begin
            next_cyc(); drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1); @(negedge clk);
            if (k == 15) chk("to_err_before", 32'(err1), 32'd0);
            chk($sformatf("to_hold%0d", k), 32'(o1), 32'(O_HOLD));
        end
        next_cyc(); drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0); @(negedge clk);
        chk("to_release_run", 32'(o1), 32'(O_RUN));
        chk("to_err_set", 32'(err1), 32'd1);
        chk("to_stall_cnt", 32'(scnt1), 32'd16);
        next_cyc(); @(negedge clk);
        chk("to_err_sticky", 32'(err1), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("to_reset_err", 32'(err1), 32'd0);
        chk("to_reset_outputs", 32'(o1), 32'(O_IDLE));
        @(posedge clk);
        #2 rst = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
